// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode and state encodings for the sequential shift register
package shift_pkg;

    localparam logic [2:0] MODE_NOP  = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Modes that consume step-counter cycles in RUN
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

    function automatic logic cnt_is_last(input logic [7:0] c);
        return c == 8'd1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q_i,
    input  logic [2:0]   mode_i,
    input  logic         i_left_i,
    input  logic         i_right_i,
    output logic [N-1:0] q_next_o,
    output logic         bit_out_o
);

    always_comb begin
        q_next_o  = q_i;
        bit_out_o = 1'b0;
        case (mode_i)
            MODE_SHL: begin
                q_next_o  = {q_i[N-2:0], i_left_i};
                bit_out_o = q_i[N-1];
            end
            MODE_SHR: begin
                q_next_o  = {i_right_i, q_i[N-1:1]};
                bit_out_o = q_i[0];
            end
            MODE_ROL: begin
                q_next_o  = {q_i[N-2:0], q_i[N-1]};
                bit_out_o = q_i[N-1];
            end
            MODE_ROR: begin
                q_next_o  = {q_i[0], q_i[N-1:1]};
                bit_out_o = q_i[0];
            end
            MODE_ASR: begin
                q_next_o  = {q_i[N-1], q_i[N-1:1]};
                bit_out_o = q_i[0];
            end
            default: begin
                q_next_o  = q_i;
                bit_out_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - multi-cycle universal shift register with start/busy/done handshake
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic [N-1:0]     data_in,
    input  logic             i_right,
    input  logic             i_left,
    output logic [N-1:0]     data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [N-1:0]     data_q, data_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [N-1:0]     step_q;
    logic             step_bit;

    shift_step #(.N(N)) u_step (
        .q_i       (data_q),
        .mode_i    (mode_q),
        .i_left_i  (i_left),
        .i_right_i (i_right),
        .q_next_o  (step_q),
        .bit_out_o (step_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_mode(mode) && (shift_cnt != '0)) begin
                        mode_d  = mode;
                        cnt_d   = shift_cnt;
                        state_d = ST_RUN;
                    end else begin
                        if (mode == MODE_LOAD) begin
                            data_d = data_in;
                        end
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                data_d = step_q;
                sout_d = step_bit;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_NOP;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign data_out   = data_q;
    assign serial_out = sout_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - directed self-checking bench for shift_reg_seq
module tb_shift_reg_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] shift_cnt = 4'd0;
    logic [7:0] data_in = 8'h00;
    logic       i_right = 1'b0;
    logic       i_left = 1'b0;
    logic [7:0] data_out;
    logic       serial_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    shift_reg_seq #(.N(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .shift_cnt  (shift_cnt),
        .data_in    (data_in),
        .i_right    (i_right),
        .i_left     (i_left),
        .data_out   (data_out),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] m, input logic [3:0] c, input logic [7:0] d);
        start     = 1'b1;
        mode      = m;
        shift_cnt = c;
        data_in   = d;
        tick();
        start     = 1'b0;
        mode      = 3'b000;
        shift_cnt = 4'd0;
        data_in   = 8'h00;
    endtask

    task automatic load(input logic [7:0] d);
        issue(3'b001, 4'd0, d);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", data_out, 8'h00);
        chk("rst_sout", {7'd0, serial_out}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        rst = 1'b0;
        tick();

        issue(3'b001, 4'd0, 8'hA5);
        chk("load_data", data_out, 8'hA5);
        chk("load_done", {7'd0, done}, 8'h01);
        chk("load_busy", {7'd0, busy}, 8'h01);
        chk("load_sout", {7'd0, serial_out}, 8'h00);
        tick();
        chk("load_done_clr", {7'd0, done}, 8'h00);
        chk("load_busy_clr", {7'd0, busy}, 8'h00);

        i_left = 1'b1;
        issue(3'b010, 4'd3, 8'h00);
        chk("shl_e0_busy", {7'd0, busy}, 8'h01);
        chk("shl_e0_data", data_out, 8'hA5);
        tick(); chk("shl_s1", data_out, 8'h4B); chk("shl_s1_sout", {7'd0, serial_out}, 8'h01);
        chk("shl_s1_done", {7'd0, done}, 8'h00);
        tick(); chk("shl_s2", data_out, 8'h97); chk("shl_s2_sout", {7'd0, serial_out}, 8'h00);
        tick(); chk("shl_s3", data_out, 8'h2F); chk("shl_s3_sout", {7'd0, serial_out}, 8'h01);
        chk("shl_done", {7'd0, done}, 8'h01);
        tick(); chk("shl_done_clr", {7'd0, done}, 8'h00); chk("shl_idle", {7'd0, busy}, 8'h00);
        i_left = 1'b0;

        load(8'hA5);
        chk("load_keeps_sout", {7'd0, serial_out}, 8'h01);
        issue(3'b101, 4'd4, 8'h00);
        tick(); chk("ror_s1", data_out, 8'hD2);
        tick(); chk("ror_s2", data_out, 8'h69);
        tick(); chk("ror_s3", data_out, 8'hB4);
        tick(); chk("ror_s4", data_out, 8'h5A); chk("ror_sout", {7'd0, serial_out}, 8'h00);
        chk("ror_done", {7'd0, done}, 8'h01);
        tick();

        issue(3'b100, 4'd8, 8'h00);
        for (int i = 0; i < 7; i++) tick();
        chk("rol8_not_done", {7'd0, done}, 8'h00);
        tick(); chk("rol8_data", data_out, 8'h5A); chk("rol8_done", {7'd0, done}, 8'h01);
        chk("rol8_sout", {7'd0, serial_out}, 8'h00);
        tick();

        load(8'h85);
        issue(3'b110, 4'd2, 8'h00);
        tick(); chk("asr_s1", data_out, 8'hC2); chk("asr_s1_sout", {7'd0, serial_out}, 8'h01);
        tick(); chk("asr_s2", data_out, 8'hE1); chk("asr_sout", {7'd0, serial_out}, 8'h00);
        chk("asr_done", {7'd0, done}, 8'h01);
        tick();

        load(8'hA5);
        i_right = 1'b0;
        issue(3'b011, 4'd2, 8'h00);
        start = 1'b1; mode = 3'b001; data_in = 8'hFF;
        tick(); chk("shr_ign_s1", data_out, 8'h52);
        tick(); chk("shr_ign_s2", data_out, 8'h29); chk("shr_ign_done", {7'd0, done}, 8'h01);
        tick(); chk("shr_ign_after", data_out, 8'h29); chk("shr_ign_idle", {7'd0, busy}, 8'h00);
        start = 1'b0; mode = 3'b000; data_in = 8'h00;
        tick();

        issue(3'b011, 4'd0, 8'h00);
        chk("shr0_done", {7'd0, done}, 8'h01);
        chk("shr0_data", data_out, 8'h29);
        tick(); chk("shr0_done_clr", {7'd0, done}, 8'h00);

        issue(3'b111, 4'd5, 8'hFF);
        chk("rsvd_done", {7'd0, done}, 8'h01);
        chk("rsvd_data", data_out, 8'h29);
        tick();

        load(8'h3C);
        i_left = 1'b0;
        issue(3'b010, 4'd10, 8'h00);
        for (int i = 0; i < 9; i++) tick();
        chk("shl10_busy", {7'd0, busy}, 8'h01);
        tick(); chk("shl10_data", data_out, 8'h00); chk("shl10_done", {7'd0, done}, 8'h01);
        tick();

        load(8'hA5);
        issue(3'b010, 4'd5, 8'h00);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_data", data_out, 8'h00);
        chk("arst_sout", {7'd0, serial_out}, 8'h00);
        chk("arst_busy", {7'd0, busy}, 8'h00);
        chk("arst_done", {7'd0, done}, 8'h00);
        tick();
        chk("arst_hold_done", {7'd0, done}, 8'h00);
        rst = 1'b0;
        tick();
        chk("arst_no_done", {7'd0, done}, 8'h00);
        issue(3'b001, 4'd0, 8'h3C);
        chk("post_rst_load", data_out, 8'h3C);
        chk("post_rst_done", {7'd0, done}, 8'h01);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
